// File: rtl/shift_issue_if.sv
// shift_issue_if: decode-side handshake, shifter drive/return and writeback
// signals of the shift issue stage, grouped for port connection.
interface shift_issue_if;
   logic        in_valid;
   logic        in_ready;
   logic [2:0]  in_funct3;
   logic        in_funct7_5;
   logic        in_is_imm;
   logic [31:0] in_rs1;
   logic [31:0] in_rs2;
   logic [4:0]  in_imm_shamt;
   logic [4:0]  in_rd;
   logic [31:0] sh_din;
   logic [4:0]  sh_shamt;
   logic        sh_al;
   logic        sh_lr;
   logic [31:0] sh_dout;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_result;
   logic [4:0]  out_rd;
   logic        out_illegal;
   modport master (
      output in_valid, in_funct3, in_funct7_5, in_is_imm, in_rs1, in_rs2, in_imm_shamt, in_rd,
      output sh_dout, out_ready,
      input  in_ready, sh_din, sh_shamt, sh_al, sh_lr, out_valid, out_result, out_rd, out_illegal
   );
   modport slave (
      input  in_valid, in_funct3, in_funct7_5, in_is_imm, in_rs1, in_rs2, in_imm_shamt, in_rd,
      input  sh_dout, out_ready,
      output in_ready, sh_din, sh_shamt, sh_al, sh_lr, out_valid, out_result, out_rd, out_illegal
   );
endinterface

// File: rtl/shift_issue_stage.sv
// shift_issue_stage: two-stage elastic pipeline feeding the external RV32
// barrel shifter (stage A operands) and capturing its result (stage B).
module shift_issue_stage #(
   parameter int XLEN = 32
) (
   input logic       clk,
   input logic       rst,
   input logic       flush,
   shift_issue_if.slave bus
);
   logic            a_valid_q, a_valid_d, b_valid_q, b_valid_d;
   logic [XLEN-1:0] a_din_q, b_result_q;
   logic [4:0]      a_shamt_q, a_rd_q, b_rd_q;
   logic            a_al_q, a_lr_q, a_ill_q, b_ill_q;
   logic            a_adv, b_adv, accept, b_load;
   logic            is_sll, is_srl, is_sra;
   logic            unused_rs2_hi;

   assign unused_rs2_hi = ^bus.in_rs2[31:5];

   assign b_adv  = !b_valid_q || bus.out_ready;
   assign a_adv  = !a_valid_q || b_adv;
   assign accept = bus.in_valid && a_adv && !flush;
   assign b_load = a_valid_q && b_adv;

   assign is_sll = bus.in_funct3 == 3'b001 && !bus.in_funct7_5;
   assign is_srl = bus.in_funct3 == 3'b101 && !bus.in_funct7_5;
   assign is_sra = bus.in_funct3 == 3'b101 &&  bus.in_funct7_5;

   always_comb begin
      a_valid_d = flush ? 1'b0 : accept || (a_valid_q && !b_adv);
      b_valid_d = flush ? 1'b0 : b_adv ? a_valid_q : b_valid_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         a_valid_q  <= 1'b0;
         b_valid_q  <= 1'b0;
         a_din_q    <= '0;
         a_shamt_q  <= '0;
         a_al_q     <= 1'b0;
         a_lr_q     <= 1'b0;
         a_rd_q     <= '0;
         a_ill_q    <= 1'b0;
         b_result_q <= '0;
         b_rd_q     <= '0;
         b_ill_q    <= 1'b0;
      end else begin
         a_valid_q <= a_valid_d;
         b_valid_q <= b_valid_d;
         // operands only change on accept so the shifter stays quiet when idle
         if (accept) begin
            a_din_q   <= bus.in_rs1;
            a_shamt_q <= bus.in_is_imm ? bus.in_imm_shamt : bus.in_rs2[4:0];
            a_al_q    <= is_sra;
            a_lr_q    <= is_srl || is_sra;
            a_rd_q    <= bus.in_rd;
            a_ill_q   <= !(is_sll || is_srl || is_sra);
         end
         if (b_load) begin
            b_result_q <= a_ill_q ? '0 : bus.sh_dout;
            b_rd_q     <= a_rd_q;
            b_ill_q    <= a_ill_q;
         end
      end
   end

   assign bus.in_ready    = a_adv;
   assign bus.sh_din      = a_din_q;
   assign bus.sh_shamt    = a_shamt_q;
   assign bus.sh_al       = a_al_q;
   assign bus.sh_lr       = a_lr_q;
   assign bus.out_valid   = b_valid_q;
   assign bus.out_result  = b_result_q;
   assign bus.out_rd      = b_rd_q;
   assign bus.out_illegal = b_ill_q;
endmodule

// File: tb/tb_shift_issue_stage.sv
// tb_shift_issue_stage: directed checks of the shift issue pipeline with a
// behavioural barrel shifter closing the sh_* loop.
module tb_shift_issue_stage;
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic flush = 1'b0;
   int   checks = 0;
   int   failures = 0;

   shift_issue_if bus ();
   shift_issue_stage dut (.clk(clk), .rst(rst), .flush(flush), .bus(bus));

   always #5 clk = ~clk;

   assign bus.sh_dout = !bus.sh_lr ? bus.sh_din << bus.sh_shamt :
                        bus.sh_al ? $unsigned($signed(bus.sh_din) >>> bus.sh_shamt) :
                        bus.sh_din >> bus.sh_shamt;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic v, input logic [2:0] f3, input logic f7, input logic imm,
                        input logic [31:0] rs1, input logic [31:0] rs2, input logic [4:0] ish,
                        input logic [4:0] rd);
      bus.in_valid     = v;
      bus.in_funct3    = f3;
      bus.in_funct7_5  = f7;
      bus.in_is_imm    = imm;
      bus.in_rs1       = rs1;
      bus.in_rs2       = rs2;
      bus.in_imm_shamt = ish;
      bus.in_rd        = rd;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_out(input string tag, input logic [31:0] res, input logic [4:0] rd,
                          input logic ill);
      chk({tag, "_valid"}, {31'b0, bus.out_valid}, 32'd1);
      chk({tag, "_result"}, bus.out_result, res);
      chk({tag, "_rd"}, {27'b0, bus.out_rd}, {27'b0, rd});
      chk({tag, "_illegal"}, {31'b0, bus.out_illegal}, {31'b0, ill});
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_sh_din"}, bus.sh_din, 32'd0);
      chk({tag, "_sh_shamt"}, {27'b0, bus.sh_shamt}, 32'd0);
      chk({tag, "_sh_al"}, {31'b0, bus.sh_al}, 32'd0);
      chk({tag, "_sh_lr"}, {31'b0, bus.sh_lr}, 32'd0);
      chk({tag, "_out_valid"}, {31'b0, bus.out_valid}, 32'd0);
      chk({tag, "_out_result"}, bus.out_result, 32'd0);
      chk({tag, "_out_rd"}, {27'b0, bus.out_rd}, 32'd0);
      chk({tag, "_out_illegal"}, {31'b0, bus.out_illegal}, 32'd0);
   endtask

   function automatic logic [31:0] model(input logic [2:0] f3, input logic f7,
                                         input logic [31:0] v, input logic [4:0] n);
      if (f3 == 3'b001 && !f7) return v << n;
      if (f3 == 3'b101 && !f7) return v >> n;
      if (f3 == 3'b101 && f7) return $unsigned($signed(v) >>> n);
      return 32'd0;
   endfunction

   logic [2:0]  r_f3 [16];
   logic        r_f7 [16];
   logic        r_imm [16];
   logic [31:0] r_rs1 [16];
   logic [31:0] r_rs2 [16];
   logic [4:0]  r_ish [16];

   initial begin
      bus.out_ready = 1'b1;
      drive(1'b0, 3'b0, 1'b0, 1'b0, 32'd0, 32'd0, 5'd0, 5'd0);
      tick();
      tick();
      chk_all_zero("reset");
      rst = 1'b0;
      #1 chk("reset_in_ready", {31'b0, bus.in_ready}, 32'd1);

      // SRA, then SLLI, SRL with rs2 upper bits, then two illegal encodings
      drive(1'b1, 3'b101, 1'b1, 1'b0, 32'h8000_0000, 32'h0000_0004, 5'd0, 5'd3);
      tick();
      chk("sra_sh_al", {31'b0, bus.sh_al}, 32'd1);
      chk("sra_sh_lr", {31'b0, bus.sh_lr}, 32'd1);
      chk("sra_sh_shamt", {27'b0, bus.sh_shamt}, 32'd4);
      chk("sra_sh_din", bus.sh_din, 32'h8000_0000);
      chk("sra_not_yet", {31'b0, bus.out_valid}, 32'd0);
      drive(1'b1, 3'b001, 1'b0, 1'b1, 32'h0000_0001, 32'h0000_0000, 5'd31, 5'd7);
      tick();
      chk_out("sra", 32'hF800_0000, 5'd3, 1'b0);
      drive(1'b1, 3'b101, 1'b0, 1'b0, 32'h8000_0000, 32'h0000_0021, 5'd0, 5'd9);
      tick();
      chk_out("slli", 32'h8000_0000, 5'd7, 1'b0);
      chk("srl_sh_shamt", {27'b0, bus.sh_shamt}, 32'd1);
      drive(1'b1, 3'b001, 1'b1, 1'b0, 32'hFFFF_FFFF, 32'h0000_0001, 5'd0, 5'd2);
      tick();
      chk_out("srl", 32'h4000_0000, 5'd9, 1'b0);
      drive(1'b1, 3'b000, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'h0000_0001, 5'd0, 5'd4);
      tick();
      chk_out("ill_f7", 32'd0, 5'd2, 1'b1);
      bus.in_valid = 1'b0;
      tick();
      chk_out("ill_f3", 32'd0, 5'd4, 1'b1);
      tick();
      chk("drain_valid", {31'b0, bus.out_valid}, 32'd0);

      // four ops with a three-cycle writeback stall after the first result
      drive(1'b1, 3'b001, 1'b0, 1'b0, 32'h0000_0003, 32'h0000_0002, 5'd0, 5'd11);
      tick();
      drive(1'b1, 3'b101, 1'b0, 1'b1, 32'h0000_00F0, 32'h0000_0000, 5'd4, 5'd12);
      tick();
      chk_out("stall_a0", 32'h0000_000C, 5'd11, 1'b0);
      bus.out_ready = 1'b0;
      drive(1'b1, 3'b101, 1'b1, 1'b0, 32'hFFFF_FF00, 32'h0000_0008, 5'd0, 5'd13);
      #1 chk("stall_in_ready0", {31'b0, bus.in_ready}, 32'd0);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk_out("stall_hold", 32'h0000_000C, 5'd11, 1'b0);
         chk("stall_in_ready", {31'b0, bus.in_ready}, 32'd0);
      end
      bus.out_ready = 1'b1;
      #1 chk("unstall_in_ready", {31'b0, bus.in_ready}, 32'd1);
      tick();
      chk_out("stall_b", 32'h0000_000F, 5'd12, 1'b0);
      drive(1'b1, 3'b001, 1'b0, 1'b1, 32'h1234_5678, 32'h0000_0000, 5'd8, 5'd14);
      tick();
      chk_out("stall_c", 32'hFFFF_FFFF, 5'd13, 1'b0);
      bus.in_valid = 1'b0;
      tick();
      chk_out("stall_d", 32'h3456_7800, 5'd14, 1'b0);
      tick();
      chk("stall_drain", {31'b0, bus.out_valid}, 32'd0);

      // flush with both stages full and a new op offered
      drive(1'b1, 3'b001, 1'b0, 1'b0, 32'h0000_0001, 32'h0000_0001, 5'd0, 5'd20);
      tick();
      drive(1'b1, 3'b001, 1'b0, 1'b0, 32'h0000_0001, 32'h0000_0002, 5'd0, 5'd21);
      tick();
      bus.out_ready = 1'b0;
      drive(1'b1, 3'b001, 1'b0, 1'b0, 32'h0000_0001, 32'h0000_0003, 5'd0, 5'd22);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      bus.in_valid = 1'b0;
      bus.out_ready = 1'b1;
      chk("flush_out_valid", {31'b0, bus.out_valid}, 32'd0);
      #1 chk("flush_in_ready", {31'b0, bus.in_ready}, 32'd1);
      for (int i = 0; i < 2; i++) begin
         tick();
         chk("flush_no_ghost", {31'b0, bus.out_valid}, 32'd0);
      end

      // reset mid-stream
      drive(1'b1, 3'b101, 1'b1, 1'b0, 32'h8765_4321, 32'h0000_0005, 5'd0, 5'd24);
      tick();
      drive(1'b1, 3'b101, 1'b1, 1'b0, 32'h8765_4321, 32'h0000_0006, 5'd0, 5'd25);
      tick();
      bus.out_ready = 1'b0;
      drive(1'b1, 3'b101, 1'b1, 1'b0, 32'h8765_4321, 32'h0000_0007, 5'd0, 5'd26);
      rst = 1'b1;
      tick();
      chk_all_zero("rst_mid");
      rst = 1'b0;
      bus.in_valid = 1'b0;
      bus.out_ready = 1'b1;
      tick();
      chk("rst_no_ghost", {31'b0, bus.out_valid}, 32'd0);

      // 16 back-to-back random shifts at full throughput
      for (int i = 0; i < 16; i++) begin
         int sel;
         sel = $urandom_range(0, 2);
         r_f3[i]  = sel == 0 ? 3'b001 : 3'b101;
         r_f7[i]  = sel == 2;
         r_imm[i] = 1'($urandom_range(0, 1));
         r_rs1[i] = $urandom;
         r_rs2[i] = $urandom;
         r_ish[i] = 5'($urandom_range(0, 31));
      end
      drive(1'b1, r_f3[0], r_f7[0], r_imm[0], r_rs1[0], r_rs2[0], r_ish[0], 5'd0);
      for (int c = 1; c < 18; c++) begin
         tick();
         if (c >= 2)
            chk_out($sformatf("rand%0d", c - 2),
                    model(r_f3[c-2], r_f7[c-2], r_rs1[c-2], r_imm[c-2] ? r_ish[c-2] : r_rs2[c-2][4:0]),
                    5'(c - 2), 1'b0);
         if (c < 16)
            drive(1'b1, r_f3[c], r_f7[c], r_imm[c], r_rs1[c], r_rs2[c], r_ish[c], 5'(c));
         else
            bus.in_valid = 1'b0;
      end
      tick();
      chk("rand_drain", {31'b0, bus.out_valid}, 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
